// File: rtl/fetch_pkg.sv
// Constants and state encoding shared by the fetch stage, instruction memory and decoder.
package fetch_pkg;

  localparam logic [5:0]  HALT_OPCODE = 6'b111111;
  localparam logic [31:0] HALT_WORD   = 32'hFC00_0000;
  localparam logic [31:0] INIT_ADDR   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt_opcode(input logic [5:0] op);
    return op == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/redirect inputs and fetch-address/status outputs of the fetch stage.
// fetch_count is present only when FETCH_COUNT_EN is defined.
interface fetch_pc_unit_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [5:0]  opcode_in;
  logic [31:0] address;
  logic [31:0] pc_plus4;
  logic        running;
  logic        halted;
  logic        err_range;
  logic        err_align;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, opcode_in,
`ifdef FETCH_COUNT_EN
    input  fetch_count,
`endif
    input  address, pc_plus4, running, halted, err_range, err_align
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, opcode_in,
`ifdef FETCH_COUNT_EN
    output fetch_count,
`endif
    output address, pc_plus4, running, halted, err_range, err_align
  );

endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-address selection (jump > branch > stall > +4) with
// alignment check on redirect targets and range check on the chosen address.
module next_pc_sel #(
  parameter int unsigned INSTRUCTION_MEM_SIZE = 128
) (
  input  logic [31:0] address,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_addr,
  output logic        update,
  output logic        bad_align,
  output logic        bad_range
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * INSTRUCTION_MEM_SIZE);

  logic redirect;

  always_comb begin
    next_addr = address + 32'd4;
    redirect  = 1'b0;
    update    = 1'b1;
    if (jump) begin
      next_addr = jump_target;
      redirect  = 1'b1;
    end else if (branch_taken) begin
      next_addr = branch_target;
      redirect  = 1'b1;
    end else if (stall) begin
      next_addr = address;
      update    = 1'b0;
    end
  end

  // Misalignment takes precedence so a single bad redirect raises one flag only.
  assign bad_align = redirect && (next_addr[1:0] != 2'b00);
  assign bad_range = !bad_align && (next_addr >= ADDR_LIMIT);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencing (INIT -> RUN -> HALT).
// Optional fetch_count output enabled by defining FETCH_COUNT_EN.
module fetch_pc_unit #(
  parameter int unsigned INSTRUCTION_MEM_SIZE = 128,
  parameter logic [31:0] INIT_ADDR            = fetch_pkg::INIT_ADDR
) (
  input logic            clk,
  input logic            rst_n,
  fetch_pc_unit_if.slave bus
);

  import fetch_pkg::*;

  fetch_state_t state;
  logic [31:0]  addr_q;
  logic         running_q;
  logic         halted_q;
  logic         err_range_q;
  logic         err_align_q;
  logic [31:0]  next_addr;
  logic         update;
  logic         bad_align;
  logic         bad_range;
  logic         halt_op;

  next_pc_sel #(
    .INSTRUCTION_MEM_SIZE(INSTRUCTION_MEM_SIZE)
  ) u_next_pc_sel (
    .address       (addr_q),
    .stall         (bus.stall),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_addr     (next_addr),
    .update        (update),
    .bad_align     (bad_align),
    .bad_range     (bad_range)
  );

  assign halt_op = is_halt_opcode(bus.opcode_in);

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;
  assign bus.fetch_count = count_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      addr_q      <= INIT_ADDR;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
`ifdef FETCH_COUNT_EN
      count_q     <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
          state     <= RUN;
          addr_q    <= '0;
          running_q <= 1'b1;
        end
        RUN: begin
          // Halt opcode at the current address outranks any redirect or error.
          if (halt_op || bad_align || bad_range) begin
            state       <= HALT;
            running_q   <= 1'b0;
            halted_q    <= 1'b1;
            err_align_q <= err_align_q | (!halt_op && bad_align);
            err_range_q <= err_range_q | (!halt_op && bad_range);
          end else begin
            addr_q <= next_addr;
`ifdef FETCH_COUNT_EN
            if (update) count_q <= count_q + 32'd1;
`endif
          end
        end
        HALT: ;
        default: begin
          state     <= HALT;
          running_q <= 1'b0;
          halted_q  <= 1'b1;
        end
      endcase
    end
  end

`ifndef FETCH_COUNT_EN
  logic unused_update;
  assign unused_update = update;
`endif

  assign bus.address   = addr_q;
  assign bus.pc_plus4  = addr_q + 32'd4;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.err_range = err_range_q;
  assign bus.err_align = err_align_q;

endmodule
